dec_scan_seq: RTL and testbench

Upstream select sequencer for the 3-to-8 DEC stage. Steps a 3-bit channel index {A,B,C} through the channels enabled in an 8-bit mask and holds each channel for a programmable dwell time. Its outputs wire directly to DEC inputs A, B and C, so DEC's one-hot D scans the enabled lines. Supports continuous scan and single-pass modes, with start/stop control and wrap/error status.

---
 rtl/dec_scan_seq.sv | 153 +++++++++++++++
 tb/tb_dec_scan_seq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/dec_scan_seq.sv
`default_nettype none
// ============================================================================
//  Module   : dec_scan_seq
//  Brief    : Channel select sequencer that drives DEC inputs A/B/C. It scans
//             the channels enabled in a mask and holds each one for DWELL cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module dec_scan_seq #(
    parameter int DWELL = 4,
    parameter int CW    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       mode,
    input  logic [7:0] mask,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       sel_valid,
    output logic       busy,
    output logic       wrap,
    output logic       err
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_DWELL = 1'b1
    } state_t;

    localparam logic [CW-1:0] c_reload = CW'(DWELL - 1);

    state_t        state_q, state_d;
    logic [2:0]    idx_q,   idx_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          mode_q,  mode_d;
    logic          wrap_q,  wrap_d;
    logic          err_q,   err_d;

    logic [2:0]    w_first;
    logic [2:0]    w_next;
    logic          w_wraps;

    function automatic logic [2:0] lowest_set(input logic [7:0] m);
        lowest_set = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) lowest_set = 3'(i);
        end
    endfunction

    // Cyclic search after cur; offset 8 lands back on cur itself, which
    // covers the single-enabled-channel case.
    function automatic logic [2:0] next_set(input logic [7:0] m, input logic [2:0] cur);
        logic [2:0] cand;
        logic       found;
        next_set = cur;
        found    = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            cand = cur + 3'(k);
            if (!found && m[cand]) begin
                next_set = cand;
                found    = 1'b1;
            end
        end
    endfunction

    always_comb begin
        w_first = lowest_set(mask);
        w_next  = next_set(mask, idx_q);
        w_wraps = (w_next <= idx_q);
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        wrap_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    if (mask == 8'h00) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_DWELL;
                        idx_d   = w_first;
                        cnt_d   = c_reload;
                        mode_d  = mode;
                    end
                end
            end
            S_DWELL: begin
                if (stop) begin
                    state_d = S_IDLE;
                    idx_d   = 3'd0;
                    cnt_d   = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (mask == 8'h00) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                    idx_d   = 3'd0;
                    cnt_d   = '0;
                end else begin
                    wrap_d = w_wraps;
                    if (w_wraps && mode_q) begin
                        state_d = S_IDLE;
                        idx_d   = 3'd0;
                        cnt_d   = '0;
                    end else begin
                        idx_d = w_next;
                        cnt_d = c_reload;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = 3'd0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= 3'd0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    assign A         = idx_q[2];
    assign B         = idx_q[1];
    assign C         = idx_q[0];
    assign sel_valid = (state_q == S_DWELL);
    assign busy      = (state_q == S_DWELL);
    assign wrap      = wrap_q;
    assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dec_scan_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dec_scan_seq
//  Brief    : Randomized scoreboard bench for dec_scan_seq with a cycle model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dec_scan_seq;

    localparam int DWELL = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, stop, mode;
    logic [7:0] mask;
    logic       A, B, C, sel_valid, busy, wrap, err;

    dec_scan_seq #(.DWELL(DWELL), .CW(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
        .mask(mask), .A(A), .B(B), .C(C), .sel_valid(sel_valid), .busy(busy),
        .wrap(wrap), .err(err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected outputs packed as {channel[2:0], sel_valid, busy, wrap, err}
    logic [6:0] exp_q[$];

    // Reference model: scan running flag, current channel, remaining hold cycles
    bit m_run    = 0;
    int m_ch     = 0;
    int m_rem    = 0;
    bit m_single = 0;

    function automatic logic [6:0] dut_out();
        return {A, B, C, sel_valid, busy, wrap, err};
    endfunction

    task automatic model_step(input bit s, input bit st, input bit md, input logic [7:0] mk);
        bit w = 0;
        bit e = 0;
        int nxt;
        logic [6:0] exp;
        if (!m_run) begin
            if (s && !st) begin
                if (mk == 0) e = 1;
                else begin
                    for (int i = 7; i >= 0; i--) if (mk[i]) m_ch = i;
                    m_rem = DWELL - 1; m_single = md; m_run = 1;
                end
            end
        end else if (st) begin
            m_run = 0; m_ch = 0;
        end else if (m_rem > 0) begin
            m_rem--;
        end else if (mk == 0) begin
            e = 1; m_run = 0; m_ch = 0;
        end else begin
            nxt = -1;
            for (int d = 1; d <= 8; d++)
                if (nxt < 0 && mk[(m_ch + d) % 8]) nxt = (m_ch + d) % 8;
            w = (nxt <= m_ch);
            if (w && m_single) begin
                m_run = 0; m_ch = 0;
            end else begin
                m_ch = nxt; m_rem = DWELL - 1;
            end
        end
        exp = {m_run ? 3'(m_ch) : 3'd0, m_run, m_run, w, e};
        exp_q.push_back(exp);
    endtask

    task automatic drive(input bit s, input bit st, input bit md, input logic [7:0] mk);
        @(negedge clk);
        #2;
        start = s; stop = st; mode = md; mask = mk;
        model_step(s, st, md, mk);
    endtask

    task automatic idle_cycles(input int n, input logic [7:0] mk);
        for (int i = 0; i < n; i++) drive(0, 0, 0, mk);
    endtask

    task automatic check_zero(input string name);
        n_tests++;
        if (dut_out() !== 7'd0) begin
            n_fail++;
            $display("FAIL %s: actual=%b required=%b (abc,sel_valid,busy,wrap,err)",
                     name, dut_out(), 7'd0);
        end
    endtask

    always @(negedge clk) begin
        logic [6:0] exp;
        if (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            n_tests++;
            if (dut_out() !== exp) begin
                n_fail++;
                $display("FAIL outputs @%0t: actual=%b required=%b (abc,sel_valid,busy,wrap,err)",
                         $time, dut_out(), exp);
            end
        end
    end

    initial begin
        rst_n = 1'b0; start = 0; stop = 0; mode = 0; mask = 8'h00;
        #1;
        check_zero("reset_state");
        #12;
        rst_n = 1'b1;

        // Continuous full scan
        idle_cycles(2, 8'hFF);
        drive(1, 0, 0, 8'hFF);
        idle_cycles(36, 8'hFF);
        drive(0, 1, 0, 8'hFF);
        idle_cycles(2, 8'hFF);

        // Single pass over channels 2,5,7
        drive(1, 0, 1, 8'b1010_0100);
        idle_cycles(16, 8'b1010_0100);

        // Empty mask start
        drive(1, 0, 0, 8'h00);
        idle_cycles(3, 8'h00);

        // Single enabled channel, continuous
        drive(1, 0, 0, 8'b0000_1000);
        idle_cycles(13, 8'b0000_1000);
        drive(0, 1, 0, 8'b0000_1000);

        // Start and stop together, then stop in the second dwell cycle of channel 1
        drive(1, 1, 0, 8'hFF);
        drive(1, 0, 0, 8'hFF);
        idle_cycles(5, 8'hFF);
        drive(0, 1, 0, 8'hFF);
        idle_cycles(2, 8'hFF);
        drive(1, 0, 0, 8'b0110_0000);
        drive(1, 0, 1, 8'b0110_0000);
        idle_cycles(6, 8'b0110_0000);

        // Mask cleared at an advance edge
        idle_cycles(1, 8'h00);
        idle_cycles(4, 8'h00);

        // Asynchronous reset in the middle of a dwell
        drive(1, 0, 0, 8'hF0);
        idle_cycles(2, 8'hF0);
        @(posedge clk);
        #3;
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        m_run = 0; m_ch = 0; m_rem = 0; m_single = 0;
        @(negedge clk);
        check_zero("reset_hold");
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        idle_cycles(4, 8'hF0);
        drive(1, 0, 0, 8'hF0);
        idle_cycles(6, 8'hF0);

        // Randomized traffic
        begin
            logic [7:0] mk = 8'h5A;
            bit s, st, md;
            for (int i = 0; i < 1500; i++) begin
                if ($urandom_range(0, 5) == 0)
                    mk = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
                s  = ($urandom_range(0, 7) == 0);
                st = ($urandom_range(0, 29) == 0);
                md = 1'($urandom);
                drive(s, st, md, mk);
            end
        end

        drive(0, 1, 0, 8'h00);
        @(negedge clk);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
